// File: rtl/fifo_flex.sv
// fifo_flex: single-clock FIFO with registered read port, occupancy flags,
// a flattened contents view ordered oldest-first, and optional sticky
// overflow/underflow flags enabled by the macro FIFO_FLEX_ERR_FLAGS_EN.
// Storage is a register array so the whole contents can be viewed and
// cleared at once. The read and write pointers wrap explicitly at DEPTH-1,
// so DEPTH does not need to be a power of two.
module fifo_flex #(
    parameter int DEPTH    = 4,
    parameter int WIDTH    = 2,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             in,
    input  logic                         push,
    input  logic                         pop,
    output logic [WIDTH-1:0]             out,
    output logic                         out_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [DEPTH*WIDTH-1:0]       queue,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [PW:0]   DEPTH_W  = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] out_reg;
    logic             out_valid_reg;
    logic             do_push;
    logic             do_pop;

    // Pointer advance with explicit wrap so any DEPTH works.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Flags come straight from the registered occupancy.
    assign full        = (count_reg == DEPTH_C);
    assign empty       = (count_reg == '0);
    assign almost_full = (count_reg >= AF_C);
    assign count       = count_reg;
    assign out         = out_reg;
    assign out_valid   = out_valid_reg;

    // A pop frees a slot in the same cycle, so push+pop on a full FIFO is accepted.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage writes; reset clears every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr_reg] <= in;
        end
    end

    // Pointers, occupancy and the registered read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= do_pop;
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                out_reg    <= mem[rd_ptr_reg];
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    // Contents view: slice gi is the gi-th oldest entry, zero when unoccupied.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
            logic [PW:0] sum;
            logic [PW:0] idx;
            assign sum = {1'b0, rd_ptr_reg} + (PW + 1)'(gi);
            assign idx = (sum >= DEPTH_W) ? sum - DEPTH_W : sum;
            assign queue[gi*WIDTH +: WIDTH] =
                (CW'(gi) < count_reg) ? mem[idx[PW-1:0]] : '0;
        end
    endgenerate

`ifdef FIFO_FLEX_ERR_FLAGS_EN
    logic overflow_reg;
    logic underflow_reg;

    // Sticky error flags: push refused while full, pop refused while empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (push && full && !pop) begin
                overflow_reg <= 1'b1;
            end
            if (pop && empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: randomized and directed stimulus for fifo_flex, checked
// every cycle against a queue-based model plus hand-computed expectations.
// Error-flag expectations follow FIFO_FLEX_ERR_FLAGS_EN as seen by this file.
module tb_fifo_flex;

    localparam int DEPTH = 4;
    localparam int WIDTH = 2;
    localparam int AF    = 3;
`ifdef FIFO_FLEX_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] in_d = 2'b00;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [1:0] dout;
    logic       out_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [2:0] count;
    logic [7:0] queue;
    logic       overflow;
    logic       underflow;

    fifo_flex #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(AF)) dut (
        .clk(clk), .reset(reset), .in(in_d), .push(push), .pop(pop),
        .out(dout), .out_valid(out_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count), .queue(queue),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain queue plus the observable registers.
    logic [1:0] mq[$];
    logic [1:0] m_out   = 2'b00;
    logic       m_valid = 1'b0;
    logic       m_ovf   = 1'b0;
    logic       m_unf   = 1'b0;
    logic       checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic p, input logic q, input logic [1:0] d);
        int  sz;
        logic pop_ok;
        logic push_ok;
        sz      = mq.size();
        pop_ok  = q && (sz > 0);
        push_ok = p && ((sz < DEPTH) || pop_ok);
        if (p && (sz == DEPTH) && !q) m_ovf = 1'b1;
        if (q && (sz == 0)) m_unf = 1'b1;
        m_valid = pop_ok;
        if (pop_ok) m_out = mq.pop_front();
        if (push_ok) mq.push_back(d);
    endtask

    task automatic model_reset();
        mq.delete();
        m_out   = 2'b00;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // One transaction: drive, clock, advance the model, report.
    task automatic cycle(input logic p, input logic q, input logic [1:0] d);
        push = p;
        pop  = q;
        in_d = d;
        @(posedge clk);
        model_step(p, q, d);
        #1;
        $display("[TB] t=%0t push=%0b pop=%0b in=%b -> count=%0d out=%b v=%0b queue=%b",
                 $time, p, q, d, count, dout, out_valid, queue);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [7:0] eq;
        if (checking && !reset) begin
            eq = '0;
            for (int i = 0; i < mq.size(); i++) eq[i*2 +: 2] = mq[i];
            chk("m_count", 32'(count), 32'(mq.size()));
            chk("m_empty", 32'(empty), 32'(mq.size() == 0));
            chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
            chk("m_afull", 32'(almost_full), 32'(mq.size() >= AF));
            chk("m_queue", 32'(queue), 32'(eq));
            chk("m_out", 32'(dout), 32'(m_out));
            chk("m_valid", 32'(out_valid), 32'(m_valid));
            chk("m_ovf", 32'(overflow), 32'(m_ovf & ERR_EN));
            chk("m_unf", 32'(underflow), 32'(m_unf & ERR_EN));
        end
    end

    // Check the full reset state right now.
    task automatic chk_reset_state(input string tag);
        chk({tag, "_out"}, 32'(dout), 0);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_afull"}, 32'(almost_full), 0);
        chk({tag, "_queue"}, 32'(queue), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_unf"}, 32'(underflow), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_reset_state("reset");
        checking = 1'b1;

        // Fill
        cycle(1, 0, 2'b01);
        cycle(1, 0, 2'b10);
        cycle(1, 0, 2'b11);
        chk("fill3_count", 32'(count), 3);
        chk("fill3_afull", 32'(almost_full), 1);
        chk("fill3_full", 32'(full), 0);
        cycle(1, 0, 2'b01);
        chk("fill4_queue", 32'(queue), 32'h79);
        chk("fill4_count", 32'(count), 4);
        chk("fill4_full", 32'(full), 1);
        cycle(1, 0, 2'b11);
        chk("ovf_queue", 32'(queue), 32'h79);
        chk("ovf_count", 32'(count), 4);
        chk("ovf_flag", 32'(overflow), 32'(ERR_EN));

        // Drain two
        cycle(0, 1, 2'b00);
        chk("drain1_out", 32'(dout), 1);
        chk("drain1_valid", 32'(out_valid), 1);
        cycle(0, 1, 2'b00);
        chk("drain2_out", 32'(dout), 2);
        chk("drain2_valid", 32'(out_valid), 1);
        chk("drain2_count", 32'(count), 2);
        chk("drain2_full", 32'(full), 0);
        chk("drain2_afull", 32'(almost_full), 0);
        cycle(0, 0, 2'b00);
        chk("hold_out", 32'(dout), 2);
        chk("hold_valid", 32'(out_valid), 0);

        // Refill to 4: contents 11,01,00,01; then push+pop while full
        cycle(1, 0, 2'b00);
        cycle(1, 0, 2'b01);
        cycle(1, 1, 2'b10);
        chk("pp_out", 32'(dout), 3);
        chk("pp_count", 32'(count), 4);
        chk("pp_full", 32'(full), 1);
        chk("pp_queue", 32'(queue), 32'h91);
        chk("pp_ovf", 32'(overflow), 32'(ERR_EN));

        // Drain to empty, then pop on empty
        repeat (4) cycle(0, 1, 2'b00);
        chk("empty_out", 32'(dout), 2);
        chk("empty_count", 32'(count), 0);
        cycle(0, 1, 2'b00);
        chk("unf_out", 32'(dout), 2);
        chk("unf_valid", 32'(out_valid), 0);
        chk("unf_flag", 32'(underflow), 32'(ERR_EN));
        cycle(1, 1, 2'b11);
        chk("pe_count", 32'(count), 1);
        chk("pe_queue", 32'(queue), 3);
        chk("pe_valid", 32'(out_valid), 0);

        // Randomized mixed traffic with wrap-around
        for (int n = 0; n < 200; n++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end

        // Reset asserted in the middle of a push
        push = 1'b1;
        pop  = 1'b0;
        in_d = 2'b11;
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk_reset_state("midrst");
        @(posedge clk);
        #1 reset = 1'b0;
        chk_reset_state("rstrel");
        cycle(1, 0, 2'b10);
        chk("post_count", 32'(count), 1);
        chk("post_queue", 32'(queue), 2);
        for (int n = 0; n < 20; n++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
